// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit : load/store sequencer between core and a ready/valid memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int W       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemEn,
  input  logic         MemWrite,
  input  logic [2:0]   Funct3,
  input  logic [W-1:0] Addr,
  input  logic [W-1:0] WriteData,
  output logic         Stall,
  output logic         Done,
  output logic [W-1:0] DOutDM,
  output logic         Misaligned,
  output logic         BusErr,
  output logic         MemReq,
  output logic         MemWe,
  output logic [W-1:0] MemAddr,
  output logic [W-1:0] MemWData,
  output logic [3:0]   MemBE,
  input  logic         MemReady,
  input  logic         MemValid,
  input  logic [W-1:0] MemRData
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [1:0]     lane;
  logic [2:0]     f3;
  logic           we_r, mis_r, berr_r;
  logic [W-1:0]   addr_r, wdata_r, dout_r;
  logic [3:0]     be_r;

  logic           illegal, timeout, capture, load_done, set_mis, set_berr;
  logic [W-1:0]   st_wdata, ld_data;
  logic [3:0]     st_be;
  logic [7:0]     rbyte;
  logic [15:0]    rhalf;

  always_comb begin
    illegal = 1'b1;
    case (Funct3)
      3'b000, 3'b100: illegal = MemWrite & Funct3[2];
      3'b001, 3'b101: illegal = Addr[0] | (MemWrite & Funct3[2]);
      3'b010:         illegal = (Addr[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so memory only needs the byte enables.
  always_comb begin
    st_wdata = WriteData;
    st_be    = 4'b1111;
    case (Funct3[1:0])
      2'b00: begin
        st_wdata = {4{WriteData[7:0]}};
        st_be    = 4'b0001 << Addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{WriteData[15:0]}};
        st_be    = Addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = WriteData;
        st_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rbyte = MemRData[7:0];
    case (lane)
      2'd0: rbyte = MemRData[7:0];
      2'd1: rbyte = MemRData[15:8];
      2'd2: rbyte = MemRData[23:16];
      2'd3: rbyte = MemRData[31:24];
      default: rbyte = MemRData[7:0];
    endcase
    rhalf = lane[1] ? MemRData[31:16] : MemRData[15:0];
    case (f3)
      3'b000:  ld_data = {{(W-8){rbyte[7]}}, rbyte};
      3'b100:  ld_data = {{(W-8){1'b0}}, rbyte};
      3'b001:  ld_data = {{(W-16){rhalf[15]}}, rhalf};
      3'b101:  ld_data = {{(W-16){1'b0}}, rhalf};
      default: ld_data = MemRData;
    endcase
  end

  assign timeout = (cnt >= CW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    load_done = 1'b0;
    set_mis   = 1'b0;
    set_berr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (MemEn) begin
          if (illegal) begin
            state_nx = S_DONE;
            set_mis  = 1'b1;
          end else begin
            state_nx = S_REQ;
            capture  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (MemReady) begin
          state_nx = we_r ? S_DONE : S_WAIT;
        end else if (timeout) begin
          state_nx = S_DONE;
          set_berr = 1'b1;
        end
      end
      S_WAIT: begin
        if (MemValid) begin
          state_nx  = S_DONE;
          load_done = 1'b1;
        end else if (timeout) begin
          state_nx = S_DONE;
          set_berr = 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      lane    <= 2'b00;
      f3      <= 3'b000;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= 4'b0000;
      dout_r  <= '0;
      mis_r   <= 1'b0;
      berr_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      // Fault flags are only ever set on the transition into DONE, so they last one cycle.
      mis_r  <= set_mis;
      berr_r <= set_berr;
      if (capture) begin
        cnt     <= '0;
        we_r    <= MemWrite;
        addr_r  <= {Addr[W-1:2], 2'b00};
        lane    <= Addr[1:0];
        f3      <= Funct3;
        wdata_r <= st_wdata;
        be_r    <= st_be;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (load_done) begin
        dout_r <= ld_data;
      end
    end
  end

  assign Stall      = ((state == S_IDLE) && MemEn) || (state == S_REQ) || (state == S_WAIT);
  assign Done       = (state == S_DONE);
  assign MemReq     = (state == S_REQ);
  assign MemWe      = we_r;
  assign MemAddr    = addr_r;
  assign MemWData   = wdata_r;
  assign MemBE      = be_r;
  assign DOutDM     = dout_r;
  assign Misaligned = mis_r;
  assign BusErr     = berr_r;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with a simple ready/valid memory responder.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemEn, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WriteData;
  logic        Stall, Done, Misaligned, BusErr;
  logic [31:0] DOutDM;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemBE;
  logic        MemReady, MemValid;
  logic [31:0] MemRData;

  always #5 clk = ~clk;

  mem_access_unit #(.W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .MemEn(MemEn), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .WriteData(WriteData), .Stall(Stall), .Done(Done), .DOutDM(DOutDM),
    .Misaligned(Misaligned), .BusErr(BusErr), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE), .MemReady(MemReady),
    .MemValid(MemValid), .MemRData(MemRData)
  );

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_dout;
    logic        e_mis;
    int          e_lat;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  int          lat;
  logic        saw_req, stall_ok, r_mis, r_berr, c_we;
  logic [31:0] r_dout, c_addr, c_wd;
  logic [3:0]  c_be;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // One access; the responder raises MemReady after rdly REQ cycles and MemValid after vdly WAIT cycles.
  task automatic run(input vec_t v, input int rdly, input int vdly, input int budget);
    int rc, wc;
    @(negedge clk);
    MemEn = 1'b1; MemWrite = v.we; Funct3 = v.f3; Addr = v.addr;
    WriteData = v.wdata; MemRData = v.rdata;
    rc = 0; wc = 0; saw_req = 1'b0; stall_ok = 1'b1; lat = -1;
    r_mis = 1'b0; r_berr = 1'b0; r_dout = 32'h0;
    c_addr = 32'h0; c_wd = 32'h0; c_be = 4'h0; c_we = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) @(negedge clk);
      MemReady = (rc >= rdly);
      MemValid = (wc >= vdly);
      #1;
      if (Done) begin
        lat = c; r_mis = Misaligned; r_berr = BusErr; r_dout = DOutDM;
        if (Stall) stall_ok = 1'b0;
        break;
      end
      if (!Stall || Misaligned || BusErr) stall_ok = 1'b0;
      if (MemReq) begin
        if (!saw_req) begin
          c_addr = MemAddr; c_wd = MemWData; c_be = MemBE; c_we = MemWe;
        end
        saw_req = 1'b1;
        rc++;
      end else if (saw_req) begin
        wc++;
      end
    end
    MemEn = 1'b0; MemReady = 1'b0; MemValid = 1'b0;
  endtask

  vec_t vecs[16];
  vec_t hv;
  logic saw_done;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"LB_103",    3'b000, 1'b0, 32'h103, 32'h0,        32'h80AABBCC, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0, 3};
    vecs[1]  = '{"LBU_101",   3'b100, 1'b0, 32'h101, 32'h0,        32'h80AABBCC, 32'h100, 4'h0, 32'h0,        32'h000000BB, 1'b0, 3};
    vecs[2]  = '{"LH_102",    3'b001, 1'b0, 32'h102, 32'h0,        32'h80AABBCC, 32'h100, 4'h0, 32'h0,        32'hFFFF80AA, 1'b0, 3};
    vecs[3]  = '{"LHU_100",   3'b101, 1'b0, 32'h100, 32'h0,        32'h1234F00D, 32'h100, 4'h0, 32'h0,        32'h0000F00D, 1'b0, 3};
    vecs[4]  = '{"LW_204",    3'b010, 1'b0, 32'h204, 32'h0,        32'hDEADBEEF, 32'h204, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 3};
    vecs[5]  = '{"SH_202",    3'b001, 1'b1, 32'h202, 32'h1234ABCD, 32'h0,        32'h200, 4'hC, 32'hABCDABCD, 32'hDEADBEEF, 1'b0, 2};
    vecs[6]  = '{"SB_301",    3'b000, 1'b1, 32'h301, 32'h000000A5, 32'h0,        32'h300, 4'h2, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 2};
    vecs[7]  = '{"SW_40C",    3'b010, 1'b1, 32'h40C, 32'hCAFEF00D, 32'h0,        32'h40C, 4'hF, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 2};
    vecs[8]  = '{"LB_000",    3'b000, 1'b0, 32'h000, 32'h0,        32'h1122337F, 32'h000, 4'h0, 32'h0,        32'h0000007F, 1'b0, 3};
    vecs[9]  = '{"LW_101",    3'b010, 1'b0, 32'h101, 32'h0,        32'h0,        32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b1, 1};
    vecs[10] = '{"LH_003",    3'b001, 1'b0, 32'h003, 32'h0,        32'h0,        32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b1, 1};
    vecs[11] = '{"F3_011",    3'b011, 1'b0, 32'h000, 32'h0,        32'h0,        32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b1, 1};
    vecs[12] = '{"SBU_000",   3'b100, 1'b1, 32'h000, 32'h0,        32'h0,        32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b1, 1};
    vecs[13] = '{"F3_111",    3'b111, 1'b0, 32'h008, 32'h0,        32'h0,        32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b1, 1};
    vecs[14] = '{"LHU_302",   3'b101, 1'b0, 32'h302, 32'h0,        32'h8001FFFF, 32'h300, 4'h0, 32'h0,        32'h00008001, 1'b0, 3};
    vecs[15] = '{"SB_003",    3'b000, 1'b1, 32'h003, 32'hFFFFFF12, 32'h0,        32'h000, 4'h8, 32'h12121212, 32'h00008001, 1'b0, 2};

    rst = 1'b1; MemEn = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; Addr = 32'h0;
    WriteData = 32'h0; MemReady = 1'b0; MemValid = 1'b0; MemRData = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_memwe", {31'd0, MemWe}, 32'd0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_memwdata", MemWData, 32'h0);
    chk("rst_membe", {28'd0, MemBE}, 32'd0);
    chk("rst_dout", DOutDM, 32'h0);
    chk("rst_flags", {30'd0, Misaligned, BusErr}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i], 0, 0, 30);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].e_lat);
      chk({vecs[i].name, "_req"}, {31'd0, saw_req}, {31'd0, ~vecs[i].e_mis});
      chk({vecs[i].name, "_mis"}, {31'd0, r_mis}, {31'd0, vecs[i].e_mis});
      chk({vecs[i].name, "_berr"}, {31'd0, r_berr}, 32'd0);
      chk({vecs[i].name, "_dout"}, r_dout, vecs[i].e_dout);
      chk({vecs[i].name, "_stall"}, {31'd0, stall_ok}, 32'd1);
      if (!vecs[i].e_mis) begin
        chk({vecs[i].name, "_addr"}, c_addr, vecs[i].e_addr);
        chk({vecs[i].name, "_we"}, {31'd0, c_we}, {31'd0, vecs[i].we});
        if (vecs[i].we) begin
          chk({vecs[i].name, "_be"}, {28'd0, c_be}, {28'd0, vecs[i].e_be});
          chk({vecs[i].name, "_wdata"}, c_wd, vecs[i].e_wd);
        end
      end
    end

    // LHU with MemReady held off 4 REQ cycles and MemValid one WAIT cycle late.
    hv = '{"LHU_slow", 3'b101, 1'b0, 32'h002, 32'h0, 32'h98761111, 32'h0, 4'h0, 32'h0, 32'h00009876, 1'b0, 8};
    run(hv, 4, 1, 40);
    chk("lhu_slow_lat", lat, 8);
    chk("lhu_slow_dout", r_dout, 32'h00009876);
    chk("lhu_slow_addr", c_addr, 32'h0);
    chk("lhu_slow_flags", {30'd0, r_mis, r_berr}, 32'd0);
    chk("lhu_slow_stall", {31'd0, stall_ok}, 32'd1);

    // Load whose data never arrives: 15 cycles in REQ+WAIT then a bus error.
    hv = '{"LW_tmo", 3'b010, 1'b0, 32'h020, 32'h0, 32'h55555555, 32'h0, 4'h0, 32'h0, 32'h00009876, 1'b0, 16};
    run(hv, 0, 1000, 40);
    chk("tmo_lat", lat, 16);
    chk("tmo_berr", {31'd0, r_berr}, 32'd1);
    chk("tmo_mis", {31'd0, r_mis}, 32'd0);
    chk("tmo_dout", r_dout, 32'h00009876);
    chk("tmo_stall", {31'd0, stall_ok}, 32'd1);
    @(negedge clk); #1;
    chk("tmo_after_flags", {29'd0, Done, Misaligned, BusErr}, 32'd0);

    // Reset while waiting for read data; the late MemValid must be ignored.
    @(negedge clk);
    MemEn = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h10;
    MemReady = 1'b1; MemValid = 1'b0; MemRData = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rstw_in_wait", {30'd0, Stall, MemReq}, 32'd2);
    rst = 1'b1; MemEn = 1'b0;
    @(negedge clk);
    rst = 1'b0; MemValid = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (Done) saw_done = 1'b1;
    end
    chk("rstw_no_done", {31'd0, saw_done}, 32'd0);
    chk("rstw_dout", DOutDM, 32'h0);
    chk("rstw_idle", {30'd0, Stall, MemReq}, 32'd0);
    MemValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: W, 32, data/address width.
REQ-002 SHALL have parameter: TIMEOUT, 15, maximum cycles in REQ+WAIT before bus error.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: MemEn  in  1  core requests load/store; held while Stall high.
REQ-006 SHALL have port: MemWrite  in  1  1=store, 0=load.
REQ-007 SHALL have port: Funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port: Addr  in  W  byte address from ALU.
REQ-009 SHALL have port: WriteData  in  W  store data (rs2).
REQ-010 SHALL have port: Stall  out  1  freeze core.
REQ-011 SHALL have port: Done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: DOutDM  out  W  aligned, extended load result, feeds writeback select.
REQ-013 SHALL have port: Misaligned  out  1  alignment/encoding fault, valid with Done.
REQ-014 SHALL have port: BusErr  out  1  timeout fault, valid with Done.
REQ-015 SHALL have port: MemReq  out  1  memory request valid.
REQ-016 SHALL have port: MemWe  out  1  request is write.
REQ-017 SHALL have port: MemAddr  out  W  word address, bits[1:0]=00.
REQ-018 SHALL have port: MemWData  out  W  lane-replicated store data.
REQ-019 SHALL have port: MemBE  out  4  byte enables.
REQ-020 SHALL have port: MemReady  in  1  memory accepts request this cycle.
REQ-021 SHALL have port: MemValid  in  1  read data valid.
REQ-022 SHALL have port: MemRData  in  W  read word.

Function
REQ-023 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-024 IDLE: MemEn=1 and legal access -> REQ, capturing MemWe, MemAddr={Addr[31:2],00}, lane k=Addr[1:0], Funct3, MemWData, MemBE.
REQ-025 IDLE: MemEn=1 and illegal access -> DONE with Misaligned=1, no MemReq; illegal = H/HU with Addr[0]=1, W with Addr[1:0]!=0, Funct3 in {011,110,111}, or store with Funct3[2]=1.
REQ-026 REQ: MemReq=1, fields stable; MemReady=1 at edge -> DONE for store, WAIT for load.
REQ-027 WAIT: MemReq=0; MemValid=1 -> DONE, DOutDM registered from MemRData; MemValid ignored in all other states.
REQ-028 DONE: Done=1 for exactly one cycle, then IDLE unconditionally; MemEn in DONE ignored.
REQ-029 Stall = (IDLE and MemEn) or REQ or WAIT; Stall=0 in DONE.
REQ-030 Load extract: B = sign-extend byte k; BU = zero-extend byte k; H/HU = sign/zero-extend halfword Addr[1]; W = whole word.
REQ-031 Store: SB MemWData = byte replicated x4, MemBE = 0001<<k; SH = halfword replicated x2, MemBE = 0011<<(2*Addr[1]); SW = WriteData, MemBE=1111.
REQ-032 DOutDM holds until next successful load; stores, faults leave it unchanged.
REQ-033 Cycle counter clears on entering REQ, increments in REQ/WAIT; reaching TIMEOUT -> DONE with BusErr=1, MemReq dropped, DOutDM unchanged.
REQ-034 Misaligned and BusErr SHALL be 0 except in the DONE cycle of a faulting access.
REQ-035 Minimum latency: store 3 cycles (IDLE, REQ, DONE); load 4 cycles (IDLE, REQ, WAIT, DONE).

Reset
REQ-036 rst=1 at edge -> IDLE, counter 0, DOutDM=0, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, MemBE=0, Done=0, Stall=0, Misaligned=0, BusErr=0.
REQ-037 rst mid-REQ/WAIT SHALL abandon the access; pending MemValid after reset ignored.

Verification
REQ-038 LB Addr=0x103, MemRData=0x80AABBCC, MemReady/MemValid immediate -> MemAddr=0x100, DOutDM=0xFFFFFF80, Done at cycle 3, Stall cycles 0-2.
REQ-039 SH Addr=0x202, WriteData=0x1234ABCD -> MemWData=0xABCDABCD, MemBE=1100, MemWe=1, Done cycle 2, DOutDM unchanged.
REQ-040 LW Addr=0x101 -> no MemReq, next cycle Done=1, Misaligned=1.
REQ-041 LHU Addr=0x002, MemReady low 4 cycles then high, MemValid 2 cycles later, MemRData=0x9876xxxx -> DOutDM=0x00009876.
REQ-042 Load, MemValid never -> Done=1, BusErr=1 after TIMEOUT=15 cycles in REQ+WAIT.
REQ-043 rst in WAIT, then MemValid=1 -> IDLE, DOutDM=0, Done never asserted.
